// File: rtl/issue_pkg.sv
// Shared types for the issue scheduler: queue entry, issue slot, tag constants.
package issue_pkg;
  localparam int IQ_DATA_W = 32;
  localparam int IQ_TAG_W  = 4;
  localparam int IQ_OP_W   = 6;
  localparam int IQ_UNIT_W = 2;  // room for up to 4 units

  localparam logic [IQ_TAG_W-1:0] TAG_NONE = '0;

  typedef struct packed {
    logic                 valid;
    logic                 ready;
    logic [IQ_UNIT_W-1:0] unit;
    logic [IQ_OP_W-1:0]   op;
    logic [IQ_DATA_W-1:0] val;
    logic [IQ_TAG_W-1:0]  src_tag;
    logic [IQ_TAG_W-1:0]  target;
  } iq_entry_t;

  typedef struct packed {
    logic [IQ_OP_W-1:0]   op;
    logic [IQ_DATA_W-1:0] val;
    logic [IQ_TAG_W-1:0]  target;
  } issue_slot_t;
endpackage

// File: rtl/iq_select.sv
// Find-first (lowest index = oldest) over a request vector.
module iq_select #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]         req,
  output logic [$clog2(DEPTH)-1:0] idx,
  output logic                     hit
);
  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = ($clog2(DEPTH))'(i);
        hit = 1'b1;
      end
    end
  end
endmodule

// File: rtl/issue_sched.sv
// Age-ordered issue queue with CDB wakeup and registered per-unit issue slots.
module issue_sched
  import issue_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int NUM_UNITS = 2,
  parameter int DATA_W    = IQ_DATA_W,
  parameter int TAG_W     = IQ_TAG_W,
  parameter int OP_W      = IQ_OP_W,
  localparam int UNIT_W   = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        id_valid,
  output logic                        id_ready,
  input  logic [UNIT_W-1:0]           id_unit,
  input  logic [OP_W-1:0]             id_op,
  input  logic [DATA_W-1:0]           id_val,
  input  logic [TAG_W-1:0]            id_src_tag,
  input  logic [TAG_W-1:0]            id_target,
  input  logic                        cdb_valid,
  input  logic [TAG_W-1:0]            cdb_tag,
  input  logic [DATA_W-1:0]           cdb_val,
  output logic [NUM_UNITS-1:0]        ex_valid,
  input  logic [NUM_UNITS-1:0]        ex_ready,
  output logic [NUM_UNITS*OP_W-1:0]   ex_op,
  output logic [NUM_UNITS*DATA_W-1:0] ex_val,
  output logic [NUM_UNITS*TAG_W-1:0]  ex_target,
  output logic [CNT_W-1:0]            occupancy
);
  localparam int IDX_W = $clog2(DEPTH);

  iq_entry_t   [DEPTH-1:0]              q, q_nxt;
  iq_entry_t                            new_e;
  logic        [CNT_W-1:0]              count, count_nxt;
  issue_slot_t [NUM_UNITS-1:0]          slot;
  logic        [NUM_UNITS-1:0]          slot_vld, slot_load, hit;
  logic        [NUM_UNITS-1:0][IDX_W-1:0] sel_idx;
  logic        [DEPTH-1:0]              issued;
  logic                                 enq;

  // No pass-through: acceptance looks only at the registered count.
  assign id_ready  = count < CNT_W'(DEPTH);
  assign enq       = id_valid && id_ready && !flush;
  assign occupancy = count;
  assign ex_valid  = slot_vld;

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
    logic [DEPTH-1:0] req;
    always_comb begin
      req = '0;
      for (int i = 0; i < DEPTH; i++)
        req[i] = q[i].valid && q[i].ready && (q[i].unit == IQ_UNIT_W'(u));
    end
    iq_select #(.DEPTH(DEPTH)) u_sel (.req(req), .idx(sel_idx[u]), .hit(hit[u]));
    assign slot_load[u] = hit[u] && (!slot_vld[u] || ex_ready[u]);
    assign ex_op[u*OP_W +: OP_W]       = slot[u].op;
    assign ex_val[u*DATA_W +: DATA_W]  = slot[u].val;
    assign ex_target[u*TAG_W +: TAG_W] = slot[u].target;
  end

  always_comb begin
    issued = '0;
    for (int u = 0; u < NUM_UNITS; u++)
      for (int i = 0; i < DEPTH; i++)
        if (slot_load[u] && sel_idx[u] == IDX_W'(i)) issued[i] = 1'b1;
  end

  always_comb begin
    new_e         = '0;
    new_e.valid   = 1'b1;
    new_e.unit    = IQ_UNIT_W'(id_unit);
    new_e.op      = id_op;
    new_e.val     = id_val;
    new_e.src_tag = id_src_tag;
    new_e.target  = id_target;
    if (id_src_tag == TAG_NONE) begin
      new_e.ready = 1'b1;
    end else if (cdb_valid && cdb_tag == id_src_tag) begin
      new_e.ready = 1'b1;
      new_e.val   = cdb_val;
    end
  end

  // Wake, drop issued entries, pack survivors toward index 0, then append.
  always_comb begin
    iq_entry_t w;
    int        p;
    q_nxt = '0;
    p     = 0;
    for (int i = 0; i < DEPTH; i++) begin
      w = q[i];
      if (!w.ready && cdb_valid && cdb_tag == w.src_tag) begin
        w.ready = 1'b1;
        w.val   = cdb_val;
      end
      if (w.valid && !issued[i]) begin
        for (int j = 0; j < DEPTH; j++)
          if (j == p) q_nxt[j] = w;
        p++;
      end
    end
    if (enq)
      for (int j = 0; j < DEPTH; j++)
        if (j == p) q_nxt[j] = new_e;
    count_nxt = CNT_W'(p) + CNT_W'(enq);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= '0;
      count <= '0;
    end else if (flush) begin
      q     <= '0;
      count <= '0;
    end else begin
      q     <= q_nxt;
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_vld <= '0;
      slot     <= '0;
    end else if (flush) begin
      slot_vld <= '0;
      slot     <= '0;
    end else begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (slot_load[u]) begin
          slot_vld[u] <= 1'b1;
          slot[u]     <= '{op:     q[sel_idx[u]].op,
                           val:    q[sel_idx[u]].val,
                           target: q[sel_idx[u]].target};
        end else if (ex_ready[u]) begin
          slot_vld[u] <= 1'b0;
        end
      end
    end
  end

  a_unit_range: assert property (@(posedge clk) disable iff (rst)
    (id_valid && id_ready) |-> (int'(id_unit) < NUM_UNITS));
endmodule

// File: tb/tb_issue_sched.sv
// Directed bench for issue_sched: scoreboard per unit plus cycle-accurate spot checks.
module tb_issue_sched;
  logic        clk = 1'b0;
  logic        rst, flush, id_valid, id_ready, cdb_valid;
  logic [0:0]  id_unit;
  logic [5:0]  id_op;
  logic [31:0] id_val, cdb_val;
  logic [3:0]  id_src_tag, id_target, cdb_tag;
  logic [1:0]  ex_valid, ex_ready;
  logic [11:0] ex_op;
  logic [63:0] ex_val;
  logic [7:0]  ex_target;
  logic [2:0]  occupancy;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] val;
    logic [3:0]  target;
  } exp_t;

  exp_t sb0[$], sb1[$];
  exp_t got, e;
  int   checks = 0, errors = 0;

  issue_sched dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_unit(id_unit), .id_op(id_op),
    .id_val(id_val), .id_src_tag(id_src_tag), .id_target(id_target),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_val(ex_val),
    .ex_target(ex_target), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic u, input logic [5:0] op, input logic [31:0] val,
                     input logic [3:0] tag, input logic [3:0] tgt);
    id_valid = 1'b1; id_unit = u; id_op = op; id_val = val;
    id_src_tag = tag; id_target = tgt;
  endtask

  task automatic idle;
    id_valid = 1'b0;
  endtask

  task automatic push(input int u, input logic [5:0] op, input logic [31:0] val,
                      input logic [3:0] tgt);
    if (u == 0) sb0.push_back('{op: op, val: val, target: tgt});
    else        sb1.push_back('{op: op, val: val, target: tgt});
  endtask

  // Monitor: every handshake must match the oldest expected op for that unit.
  always @(negedge clk) begin
    if (!rst) begin
      for (int u = 0; u < 2; u++) begin
        if (ex_valid[u] && ex_ready[u]) begin
          got = '{op: ex_op[u*6 +: 6], val: ex_val[u*32 +: 32], target: ex_target[u*4 +: 4]};
          if (u == 0) begin
            if (sb0.size() == 0) chk("spurious issue u0", 64'(ex_valid[0]), 64'd0);
            else begin e = sb0.pop_front(); chk("issue u0", 64'(got), 64'(e)); end
          end else begin
            if (sb1.size() == 0) chk("spurious issue u1", 64'(ex_valid[1]), 64'd0);
            else begin e = sb1.pop_front(); chk("issue u1", 64'(got), 64'(e)); end
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; id_valid = 1'b0; id_unit = '0; id_op = '0; id_val = '0;
    id_src_tag = '0; id_target = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_val = '0;
    ex_ready = 2'b00;
    tick; tick;
    chk("reset ex_valid", 64'(ex_valid), 64'd0);
    chk("reset occupancy", 64'(occupancy), 64'd0);
    chk("reset id_ready", 64'(id_ready), 64'd1);
    chk("reset ex_op", 64'(ex_op), 64'd0);
    rst = 1'b0;
    tick;

    // T1: async reset mid-traffic
    drv(0, 6'd1, 32'h11, 4'd0, 4'd1); tick;
    drv(0, 6'd2, 32'h22, 4'd0, 4'd2); tick;
    idle; tick;
    chk("t1 pre occupancy", 64'(occupancy), 64'd1);
    chk("t1 pre ex_valid", 64'(ex_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t1 rst ex_valid", 64'(ex_valid), 64'd0);
    chk("t1 rst occupancy", 64'(occupancy), 64'd0);
    chk("t1 rst id_ready", 64'(id_ready), 64'd1);
    tick;
    rst = 1'b0;
    tick;

    // T2: minimum latency C -> C+2, slot drains at C+3
    ex_ready = 2'b11;
    drv(0, 6'd5, 32'h1234, 4'd0, 4'd3); push(0, 6'd5, 32'h1234, 4'd3);
    tick; idle;
    chk("t2 c1 ex_valid", 64'(ex_valid[0]), 64'd0);
    tick;
    chk("t2 c2 ex_valid", 64'(ex_valid[0]), 64'd1);
    tick;
    chk("t2 c3 ex_valid", 64'(ex_valid[0]), 64'd0);

    // T3: wakeup via CDB, then same-cycle bypass
    drv(1, 6'd9, 32'h0, 4'd7, 4'd4);
    tick; idle;
    tick; tick; tick;
    chk("t3 waiting ex_valid", 64'(ex_valid[1]), 64'd0);
    chk("t3 waiting occupancy", 64'(occupancy), 64'd1);
    tick;
    cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_val = 32'hDEAD; push(1, 6'd9, 32'hDEAD, 4'd4);
    tick; cdb_valid = 1'b0;
    chk("t3 c6 ex_valid", 64'(ex_valid[1]), 64'd0);
    tick;
    chk("t3 c7 ex_valid", 64'(ex_valid[1]), 64'd1);
    tick;
    drv(1, 6'd10, 32'h0, 4'd7, 4'd5);
    cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_val = 32'hBEEF; push(1, 6'd10, 32'hBEEF, 4'd5);
    tick; idle; cdb_valid = 1'b0;
    chk("t3 bypass +1 ex_valid", 64'(ex_valid[1]), 64'd0);
    tick;
    chk("t3 bypass +2 ex_valid", 64'(ex_valid[1]), 64'd1);
    tick;

    // T4: younger ready ops bypass a blocked older op
    ex_ready = 2'b00;
    drv(0, 6'd20, 32'h20, 4'd0, 4'd1); push(0, 6'd20, 32'h20, 4'd1); tick;
    drv(1, 6'd21, 32'h21, 4'd0, 4'd2); push(1, 6'd21, 32'h21, 4'd2); tick;
    drv(0, 6'd22, 32'h0, 4'd2, 4'd6); tick;
    drv(0, 6'd23, 32'h23, 4'd0, 4'd7); push(0, 6'd23, 32'h23, 4'd7); tick;
    drv(1, 6'd24, 32'h24, 4'd0, 4'd8); push(1, 6'd24, 32'h24, 4'd8); tick;
    idle;
    chk("t4 occupancy 3", 64'(occupancy), 64'd3);
    chk("t4 slots full", 64'(ex_valid), 64'd3);
    ex_ready = 2'b11;
    tick;
    chk("t4 occupancy 1", 64'(occupancy), 64'd1);
    chk("t4 B C issued", 64'(ex_valid), 64'd3);
    cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_val = 32'hA5A5; push(0, 6'd22, 32'hA5A5, 4'd6);
    tick; cdb_valid = 1'b0;
    chk("t4 A woken occupancy", 64'(occupancy), 64'd1);
    chk("t4 slots empty", 64'(ex_valid), 64'd0);
    tick;
    chk("t4 occupancy 0", 64'(occupancy), 64'd0);
    chk("t4 A issued", 64'(ex_valid), 64'd1);
    tick;

    // T5: backpressure, full queue, in-order drain
    ex_ready = 2'b00;
    for (int k = 1; k <= 6; k++) begin
      drv(0, 6'(30 + k), 32'h100 + 32'(k), 4'd0, 4'(k));
      push(0, 6'(30 + k), 32'h100 + 32'(k), 4'(k));
      if (k < 6) tick;
    end
    chk("t5 full occupancy", 64'(occupancy), 64'd4);
    chk("t5 full id_ready", 64'(id_ready), 64'd0);
    chk("t5 slot holds op1", 64'(ex_op[5:0]), 64'd31);
    tick;
    chk("t5 stable op1", 64'(ex_op[5:0]), 64'd31);
    chk("t5 stable occupancy", 64'(occupancy), 64'd4);
    ex_ready = 2'b11;
    chk("t5 no pass-through", 64'(id_ready), 64'd0);
    tick;
    chk("t5 id_ready reopens", 64'(id_ready), 64'd1);
    tick; idle;
    for (int k = 3; k <= 6; k++) begin
      chk("t5 drain order", 64'(ex_op[5:0]), 64'(30 + k));
      tick;
    end
    tick;
    chk("t5 drained occupancy", 64'(occupancy), 64'd0);
    chk("t5 drained ex_valid", 64'(ex_valid), 64'd0);

    // T6: flush beats enqueue and wakeup
    ex_ready = 2'b00;
    drv(0, 6'd40, 32'h40, 4'd0, 4'd1); tick;
    drv(1, 6'd41, 32'h41, 4'd0, 4'd2); tick;
    drv(0, 6'd42, 32'h42, 4'd0, 4'd3); tick;
    drv(1, 6'd43, 32'h0,  4'd5, 4'd4); tick;
    drv(0, 6'd44, 32'h44, 4'd0, 4'd5); tick;
    idle;
    chk("t6 pre occupancy", 64'(occupancy), 64'd3);
    chk("t6 pre slots", 64'(ex_valid), 64'd3);
    flush = 1'b1;
    drv(1, 6'd45, 32'h55, 4'd0, 4'd9);
    cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_val = 32'h5555;
    chk("t6 id_ready pre-flush", 64'(id_ready), 64'd1);
    tick;
    flush = 1'b0; idle; cdb_valid = 1'b0;
    chk("t6 flush ex_valid", 64'(ex_valid), 64'd0);
    chk("t6 flush occupancy", 64'(occupancy), 64'd0);
    ex_ready = 2'b11;
    tick; tick; tick; tick;
    chk("t6 quiet ex_valid", 64'(ex_valid), 64'd0);
    chk("t6 quiet occupancy", 64'(occupancy), 64'd0);

    chk("sb0 drained", 64'(sb0.size()), 64'd0);
    chk("sb1 drained", 64'(sb1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
